// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared FSM encoding and frame constants for the DAC SPI transmitter
package dac_spi_pkg;
   typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, LDAC, DONE} state_e;
   localparam int FRAME_LEN = 16;
   localparam logic [3:0] CFG_BITS = 4'b0011;
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: emits a one-cycle tick every ClkDiv enabled cycles, cleared while disabled
module spi_tick_gen #(
   parameter int ClkDiv = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tick_o
);
   localparam int CW = ClkDiv > 1 ? $clog2(ClkDiv) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   assign tick_o = en_i && (cnt_q == CW'(ClkDiv - 1));
   // wrap on terminal count, hold at zero while disabled
   always_comb cnt_d = (!en_i || tick_o) ? '0 : cnt_q + 1'b1;
   // counter register
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: sends {cfg, code} as a 16-bit mode-0 SPI frame, then strobes LDAC
module dac_spi_tx
   import dac_spi_pkg::*;
#(
   parameter int Width = 12,
   parameter int ClkDiv = 4,
   parameter logic [3:0] CfgBits = CFG_BITS
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [Width-1:0] code_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             cs_n_o,
   output logic             sclk_o,
   output logic             mosi_o,
   output logic             ldac_n_o
);
   state_e state_q, state_d;
   logic [FRAME_LEN-1:0] shreg_q, shreg_d, frame;
   logic [3:0] bit_q, bit_d;
   logic cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic ldac_n_q, ldac_n_d, busy_q, busy_d, done_q, done_d;
   logic tick, tick_en;
   assign frame = {CfgBits, code_i};
   assign tick_en = state_q inside {CS_SETUP, SHIFT, CS_HOLD, LDAC};
   spi_tick_gen #(.ClkDiv(ClkDiv)) u_tick (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (tick_en),
      .tick_o(tick)
   );
   // next-state and registered-output logic; every phase advances on a tick
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d = bit_q;
      cs_n_d = cs_n_q;
      sclk_d = sclk_q;
      mosi_d = mosi_q;
      ldac_n_d = ldac_n_q;
      busy_d = busy_q;
      done_d = done_q;
      case (state_q)
         IDLE: if (start_i) begin
            shreg_d = frame;
            mosi_d = frame[FRAME_LEN-1];
            cs_n_d = 1'b0;
            busy_d = 1'b1;
            state_d = CS_SETUP;
         end
         CS_SETUP: if (tick) state_d = SHIFT;
         SHIFT: if (tick) begin
            sclk_d = ~sclk_q;
            if (sclk_q && bit_q == 4'(FRAME_LEN - 1)) begin
               bit_d = '0;
               shreg_d = '0;
               state_d = CS_HOLD;
            end else if (sclk_q) begin
               bit_d = bit_q + 1'b1;
               shreg_d = shreg_q << 1;
               mosi_d = shreg_q[FRAME_LEN-2];
            end
         end
         CS_HOLD: if (tick) begin
            cs_n_d = 1'b1;
            mosi_d = 1'b0;
            ldac_n_d = 1'b0;
            state_d = LDAC;
         end
         LDAC: if (tick) begin
            ldac_n_d = 1'b1;
            done_d = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done_d = 1'b0;
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and output registers; reset aborts any frame in flight
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q <= IDLE;
         shreg_q <= '0;
         bit_q <= '0;
         cs_n_q <= 1'b1;
         sclk_q <= 1'b0;
         mosi_q <= 1'b0;
         ldac_n_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q <= bit_d;
         cs_n_q <= cs_n_d;
         sclk_q <= sclk_d;
         mosi_q <= mosi_d;
         ldac_n_q <= ldac_n_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign cs_n_o = cs_n_q;
   assign sclk_o = sclk_q;
   assign mosi_o = mosi_q;
   assign ldac_n_o = ldac_n_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: random-code frames checked against a frame/timing reference model
module tb_dac_spi_tx;
   localparam int D4 = 4;
   localparam int D1 = 1;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic start4 = 1'b0, start1 = 1'b0;
   logic [11:0] code4 = '0, code1 = '0;
   logic busy4, done4, cs4, sclk4, mosi4, ldac4;
   logic busy1, done1, cs1, sclk1, mosi1, ldac1;
   int n_chk = 0, n_pass = 0;
   always #5 clk_i = ~clk_i;
   dac_spi_tx #(.ClkDiv(D4)) dut4 (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start4), .code_i(code4),
      .busy_o(busy4), .done_o(done4), .cs_n_o(cs4), .sclk_o(sclk4),
      .mosi_o(mosi4), .ldac_n_o(ldac4)
   );
   dac_spi_tx #(.ClkDiv(D1)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start1), .code_i(code1),
      .busy_o(busy1), .done_o(done1), .cs_n_o(cs1), .sclk_o(sclk1),
      .mosi_o(mosi1), .ldac_n_o(ldac1)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask
   function automatic logic [15:0] model_frame(input logic [11:0] c);
      return {4'b0011, c};
   endfunction
   // one ClkDiv=4 frame: optional ignored start pulses and a code change after accept
   task automatic frame4(input string tn, input logic [11:0] code, input bit extra, input bit chg);
      logic [15:0] fr, exp_f;
      int rises, done_at, ldac_lo, cs_falls, cs_bad, k;
      logic ps, pc;
      fr = '0; rises = 0; done_at = -1; ldac_lo = 0; cs_falls = 0; cs_bad = 0; k = 0;
      exp_f = model_frame(code);
      @(negedge clk_i);
      chk({tn, "_idle_busy"}, 32'(busy4), 32'd0);
      code4 = code;
      start4 = 1'b1;
      @(posedge clk_i);
      #1;
      start4 = 1'b0;
      chk({tn, "_acc_busy"}, 32'(busy4), 32'd1);
      chk({tn, "_acc_cs"}, 32'(cs4), 32'd0);
      chk({tn, "_acc_mosi"}, 32'(mosi4), 32'(exp_f[15]));
      if (chg) code4 = ~code;
      ps = sclk4;
      pc = cs4;
      while (k < 400 && !(done_at >= 0 && k >= done_at + 20)) begin
         @(posedge clk_i);
         #1;
         k++;
         if (sclk4 && !ps) begin
            fr = {fr[14:0], mosi4};
            rises++;
         end
         if (!cs4 && pc) cs_falls++;
         if (cs4 && done_at < 0 && rises < 16) cs_bad++;
         if (!ldac4) ldac_lo++;
         if (done4 && done_at < 0) begin
            done_at = k;
            chk({tn, "_done_busy"}, 32'(busy4), 32'd1);
         end
         if (done_at >= 0 && k == done_at + 1) begin
            chk({tn, "_busy_drop"}, 32'(busy4), 32'd0);
            chk({tn, "_done_pulse"}, 32'(done4), 32'd0);
         end
         ps = sclk4;
         pc = cs4;
         start4 = extra && (k == 10 || k == 50 || k == done_at);
      end
      start4 = 1'b0;
      chk({tn, "_frame"}, 32'(fr), 32'(exp_f));
      chk({tn, "_rises"}, 32'(rises), 32'd16);
      chk({tn, "_done_at"}, 32'(done_at), 32'(35 * D4));
      chk({tn, "_ldac_lo"}, 32'(ldac_lo), 32'(D4));
      chk({tn, "_cs_refall"}, 32'(cs_falls), 32'd0);
      chk({tn, "_cs_gap"}, 32'(cs_bad), 32'd0);
   endtask
   initial begin
      logic [11:0] rc;
      logic [15:0] fr;
      int k, rises, nf, dones, falls;
      logic ps, pc;
      int acc[$];
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_cs", 32'(cs4), 32'd1);
      chk("rst_sclk", 32'(sclk4), 32'd0);
      chk("rst_mosi", 32'(mosi4), 32'd0);
      chk("rst_ldac", 32'(ldac4), 32'd1);
      chk("rst_busy", 32'(busy4), 32'd0);
      chk("rst_done", 32'(done4), 32'd0);
      chk("rst_cs1", 32'(cs1), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b0;
      frame4("f333", 12'h333, 1'b0, 1'b0);
      frame4("f000", 12'h000, 1'b0, 1'b0);
      frame4("ffff", 12'hfff, 1'b0, 1'b0);
      frame4("ign", 12'($urandom_range(0, 4095)), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) frame4("rnd", 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
      frame4("chg", 12'($urandom_range(0, 4095)), 1'b0, 1'b1);
      // abort mid-SHIFT after seven bits
      rc = 12'($urandom_range(0, 4095));
      @(negedge clk_i);
      code4 = rc;
      start4 = 1'b1;
      @(posedge clk_i);
      #1;
      start4 = 1'b0;
      rises = 0;
      k = 0;
      ps = sclk4;
      while (rises < 7 && k < 200) begin
         @(posedge clk_i);
         #1;
         k++;
         if (sclk4 && !ps) rises++;
         ps = sclk4;
      end
      chk("abort_reached", 32'(rises), 32'd7);
      #2;
      rst_i = 1'b1;
      #1;
      chk("abort_cs", 32'(cs4), 32'd1);
      chk("abort_sclk", 32'(sclk4), 32'd0);
      chk("abort_ldac", 32'(ldac4), 32'd1);
      chk("abort_busy", 32'(busy4), 32'd0);
      chk("abort_done", 32'(done4), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      dones = 0;
      falls = 0;
      pc = cs4;
      repeat (200) begin
         @(posedge clk_i);
         #1;
         if (done4) dones++;
         if (!cs4 && pc) falls++;
         pc = cs4;
      end
      chk("abort_no_done", 32'(dones), 32'd0);
      chk("abort_no_cs", 32'(falls), 32'd0);
      frame4("post_rst", 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
      // ClkDiv=1, start held high, code stepped on each done
      @(negedge clk_i);
      code1 = '0;
      start1 = 1'b1;
      fr = '0;
      rises = 0;
      nf = 0;
      k = 0;
      ps = sclk1;
      pc = cs1;
      while (nf < 5 && k < 400) begin
         @(posedge clk_i);
         #1;
         k++;
         if (!cs1 && pc) acc.push_back(k);
         if (sclk1 && !ps) begin
            fr = {fr[14:0], mosi1};
            rises++;
         end
         if (done1) begin
            chk("b2b_frame", 32'(fr), 32'(model_frame(12'(nf * 819))));
            chk("b2b_rises", 32'(rises), 32'd16);
            nf++;
            fr = '0;
            rises = 0;
            code1 = code1 + 12'd819;
            if (nf == 5) start1 = 1'b0;
         end
         ps = sclk1;
         pc = cs1;
      end
      start1 = 1'b0;
      chk("b2b_frames", 32'(nf), 32'd5);
      chk("b2b_accepts", 32'(acc.size()), 32'd5);
      for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'(35 * D1 + 2));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
Serializes a 12-bit DAC code onto an SPI bus for a 12-bit single-channel voltage DAC (MCP4921-style 16-bit frame), then pulses LDAC so the new voltage takes effect.
Sits directly downstream of the voltage-step counter: count_o of that counter drives code_i.
The sweep FSM issues start_i after each counter update and waits for done_o before the next step or ADC read.

Parameters:
Width, 12, DAC code width. Fixed at 12 so that Width + 4 config bits = 16-bit frame.
ClkDiv, 4, SCLK half-period in clk_i cycles. Must be >= 1. SCLK frequency = f_clk / (2*ClkDiv).
CfgBits, 4'b0011, frame bits [15:12]: A/B=0, BUF=0, GA=1 (1x gain), SHDN=1 (active).

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  request one frame; sampled only while busy_o=0
code_i  in  Width  DAC code; latched on the edge that accepts start_i
busy_o  out  1  high from the accept edge until the cycle after done_o
done_o  out  1  one-cycle pulse when the frame and LDAC pulse are complete
cs_n_o  out  1  SPI chip select, active-low
sclk_o  out  1  SPI clock, mode 0 (idle low, DAC samples on rising edge)
mosi_o  out  1  SPI data, MSB first
ldac_n_o  out  1  DAC latch strobe, active-low

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset values, and any time rst_i is asserted, including mid-frame (no partial-frame completion after reset):
  - cs_n_o=1, sclk_o=0, mosi_o=0, ldac_n_o=1
  - busy_o=0, done_o=0
  - state=IDLE, shift register=0, counters=0
- Tick generator: counts 0..ClkDiv-1 and emits tick on terminal count. It is held in reset outside the CS_SETUP..LDAC states.
- FSM states and transitions:
  - IDLE: busy_o=0. On start_i=1, latch shreg={CfgBits, code_i}, go to CS_SETUP. On that same edge: cs_n_o<=0, mosi_o<=bit15, busy_o<=1.
  - CS_SETUP: ClkDiv cycles with sclk low, then go to SHIFT.
  - SHIFT: 16 bits. Per bit: sclk_o low for ClkDiv cycles, then high for ClkDiv cycles.
    - On each high->low transition (except after bit 0), shift left and present the next bit on mosi_o.
    - After the 16th high phase: sclk_o<=0, go to CS_HOLD. The bit counter is 4 bits and terminates at 15.
  - CS_HOLD: ClkDiv cycles, sclk low, cs_n_o low. On exit: cs_n_o<=1, mosi_o<=0, ldac_n_o<=0, go to LDAC.
  - LDAC: ldac_n_o low for ClkDiv cycles. On exit: ldac_n_o<=1, done_o<=1, go to DONE.
  - DONE: one cycle. done_o=1, busy_o=1. Next edge: done_o<=0, busy_o<=0, go to IDLE.
- Latency: done_o is high in the cycle starting 35*ClkDiv edges after the accept edge (140 for ClkDiv=4). The next start is accepted no earlier than 35*ClkDiv+2 edges after the previous accept.
- Exactly 16 sclk rising edges per frame. mosi_o is stable for ClkDiv cycles before and after each rising edge.
- start_i while busy_o=1 (including the DONE cycle) is ignored; it is not queued.
- code_i changes after the accept edge have no effect on the current frame.
- start_i held high continuously: one frame per 35*ClkDiv+2 cycles.

Decomposition:
- Package dac_spi_pkg contains:
  - state encoding localparams: IDLE, CS_SETUP, SHIFT, CS_HOLD, LDAC, DONE
  - FRAME_LEN=16
  - default CFG_BITS=4'b0011
- Sub-module spi_tick_gen(ClkDiv): clk_i, rst_i, en_i → tick_o. It is reused by the planned ADC SPI reader.

Test Plan:
- ClkDiv=4, code_i=819 (0x333), start pulse → mosi sampled on 16 sclk rising edges = 0x3333; cs_n low throughout; done at edge 140 after accept; ldac_n low 4 cycles before done.
- code_i=0, then code_i=4095 → frames 0x3000 and 0x3FFF; busy_o drops one cycle after each done_o.
- start_i pulsed at cycles 10, 50 and at the DONE cycle of frame 1 → only one frame; exactly 16 sclk rises; no second cs_n fall.
- rst_i asserted mid-SHIFT (after 7 bits) → same cycle cs_n_o=1, sclk_o=0, ldac_n_o=1, busy_o=0; no done_o; next start sends a full, correct frame.
- ClkDiv=1, start_i held high with code incrementing by 819 per done → back-to-back frames 0x3000, 0x3333, 0x3666, 0x3999, 0x3CCC; start-to-start spacing 37 cycles.
- code_i changed the cycle after accept → transmitted frame reflects the latched value.
